// File: rtl/onehot_latch_sched.sv
// Session scheduler: round-robin arbitration of one-hot set requests into a sticky latch vector,
// with validation and an optional prerequisite guard on one bit.
module onehot_latch_sched #(
    parameter int          W        = 64,
    parameter int          N        = 4,
    parameter int          DEP_BIT  = 0,
    parameter logic [W-1:0] DEP_MASK = {W{1'b0}},
    localparam int         CW       = $clog2(W + 1),
    localparam int         IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_bits,
    output logic [N-1:0]     req_ready,
    output logic [W-1:0]     latch,
    output logic [CW-1:0]    set_cnt,
    output logic             busy,
    output logic             done,
    output logic             rej_valid,
    output logic [IW-1:0]    rej_id,
    output logic [1:0]       rej_code
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [1:0] CodeNotOneHot = 2'b01;
    localparam logic [1:0] CodeDepMiss   = 2'b10;

    state_e          r_state;
    logic [W-1:0]    r_latch;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_ptr;
    logic            r_rej_valid;
    logic [IW-1:0]   r_rej_id;
    logic [1:0]      r_rej_code;

    logic            w_found;
    logic [IW-1:0]   w_gnt_idx;
    logic [N-1:0]    w_ready;
    logic [W-1:0]    w_vec;
    logic            w_xfer;
    logic            w_onehot;
    logic            w_dep_miss;
    logic            w_accept;
    logic            w_new_bit;
    logic [W-1:0]    w_latch_nxt;
    logic [IW-1:0]   w_ptr_nxt;

    // Round-robin search starting at the pointer, wrapping N-1 -> 0.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % N]) begin
                w_found   = 1'b1;
                w_gnt_idx = IW'((int'(r_ptr) + k) % N);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == StRun && !start && w_found) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_xfer      = |w_ready;
    assign w_vec       = req_bits[int'(w_gnt_idx) * W +: W];
    assign w_onehot    = (w_vec != '0) && ((w_vec & (w_vec - W'(1))) == '0);
    assign w_dep_miss  = (DEP_MASK != '0) && w_vec[DEP_BIT] && ((r_latch & DEP_MASK) == '0);
    assign w_accept    = w_xfer && w_onehot && !w_dep_miss;
    assign w_new_bit   = (w_vec & ~r_latch) != '0;
    assign w_latch_nxt = r_latch | w_vec;
    assign w_ptr_nxt   = (w_gnt_idx == IW'(N - 1)) ? '0 : w_gnt_idx + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_latch     <= '0;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_rej_valid <= 1'b0;
            r_rej_id    <= '0;
            r_rej_code  <= '0;
        end else begin
            r_rej_valid <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state <= StRun;
                        r_latch <= '0;
                        r_cnt   <= '0;
                        r_ptr   <= '0;
                    end
                end
                StRun: begin
                    if (start) begin
                        r_latch <= '0;
                        r_cnt   <= '0;
                        r_ptr   <= '0;
                    end else if (w_xfer) begin
                        // Rejected transfers are still consumed and advance the pointer.
                        r_ptr <= w_ptr_nxt;
                        if (w_accept) begin
                            r_latch <= w_latch_nxt;
                            if (w_new_bit) begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                            if (w_latch_nxt == '1) begin
                                r_state <= StDone;
                            end
                        end else begin
                            r_rej_valid <= 1'b1;
                            r_rej_id    <= w_gnt_idx;
                            r_rej_code  <= w_onehot ? CodeDepMiss : CodeNotOneHot;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign latch     = r_latch;
    assign set_cnt   = r_cnt;
    assign busy      = (r_state == StRun);
    assign done      = (r_state == StDone);
    assign rej_valid = r_rej_valid;
    assign rej_id    = r_rej_id;
    assign rej_code  = r_rej_code;

endmodule

// File: tb/tb_onehot_latch_sched.sv
// Directed table-driven bench for onehot_latch_sched (W=8, N=2, DEP_BIT=5, DEP_MASK=8'h06).
module tb_onehot_latch_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  req_valid;
    logic [15:0] req_bits;
    logic [1:0]  req_ready;
    logic [7:0]  latch;
    logic [3:0]  set_cnt;
    logic        busy;
    logic        done;
    logic        rej_valid;
    logic [0:0]  rej_id;
    logic [1:0]  rej_code;

    int checks;
    int failures;

    onehot_latch_sched #(
        .W(8),
        .N(2),
        .DEP_BIT(5),
        .DEP_MASK(8'h06)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .req_valid(req_valid),
        .req_bits(req_bits),
        .req_ready(req_ready),
        .latch(latch),
        .set_cnt(set_cnt),
        .busy(busy),
        .done(done),
        .rej_valid(rej_valid),
        .rej_id(rej_id),
        .rej_code(rej_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [1:0] v;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [1:0] rdy;
        logic [7:0] lat;
        logic [3:0] cnt;
        logic       bsy;
        logic       dn;
        logic       rv;
        logic       rid;
        logic [1:0] rcode;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] v, input logic [7:0] b0,
                         input logic [7:0] b1);
        start     = st;
        req_valid = v;
        req_bits  = {b1, b0};
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        //          st  v      b0     b1     rdy    lat    cnt  bsy dn rv rid rcode
        tbl[0]  = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 4'd0, 1, 0, 0, 0, 2'b00};
        tbl[1]  = '{1'b0, 2'b01, 8'h01, 8'h00, 2'b01, 8'h01, 4'd1, 1, 0, 0, 0, 2'b00};
        tbl[2]  = '{1'b0, 2'b11, 8'h01, 8'h02, 2'b10, 8'h03, 4'd2, 1, 0, 0, 0, 2'b00};
        tbl[3]  = '{1'b0, 2'b11, 8'h01, 8'h02, 2'b01, 8'h03, 4'd2, 1, 0, 0, 0, 2'b00};
        tbl[4]  = '{1'b0, 2'b11, 8'h01, 8'h02, 2'b10, 8'h03, 4'd2, 1, 0, 0, 0, 2'b00};
        tbl[5]  = '{1'b0, 2'b11, 8'h01, 8'h02, 2'b01, 8'h03, 4'd2, 1, 0, 0, 0, 2'b00};
        tbl[6]  = '{1'b0, 2'b11, 8'h01, 8'h02, 2'b10, 8'h03, 4'd2, 1, 0, 0, 0, 2'b00};
        tbl[7]  = '{1'b0, 2'b01, 8'h03, 8'h00, 2'b01, 8'h03, 4'd2, 1, 0, 1, 0, 2'b01};
        tbl[8]  = '{1'b1, 2'b11, 8'h01, 8'h02, 2'b00, 8'h00, 4'd0, 1, 0, 0, 0, 2'b01};
        tbl[9]  = '{1'b0, 2'b01, 8'h01, 8'h00, 2'b01, 8'h01, 4'd1, 1, 0, 0, 0, 2'b01};
        tbl[10] = '{1'b0, 2'b10, 8'h00, 8'h20, 2'b10, 8'h01, 4'd1, 1, 0, 1, 1, 2'b10};
        tbl[11] = '{1'b0, 2'b01, 8'h04, 8'h00, 2'b01, 8'h05, 4'd2, 1, 0, 0, 1, 2'b10};
        tbl[12] = '{1'b0, 2'b10, 8'h00, 8'h20, 2'b10, 8'h25, 4'd3, 1, 0, 0, 1, 2'b10};
        tbl[13] = '{1'b0, 2'b01, 8'h01, 8'h00, 2'b01, 8'h25, 4'd3, 1, 0, 0, 1, 2'b10};
        tbl[14] = '{1'b0, 2'b01, 8'h00, 8'h00, 2'b01, 8'h25, 4'd3, 1, 0, 1, 0, 2'b01};
        tbl[15] = '{1'b0, 2'b11, 8'h02, 8'h08, 2'b10, 8'h2D, 4'd4, 1, 0, 0, 0, 2'b01};
        tbl[16] = '{1'b0, 2'b11, 8'h02, 8'h08, 2'b01, 8'h2F, 4'd5, 1, 0, 0, 0, 2'b01};
        tbl[17] = '{1'b0, 2'b10, 8'h00, 8'h10, 2'b10, 8'h3F, 4'd6, 1, 0, 0, 0, 2'b01};
        tbl[18] = '{1'b0, 2'b01, 8'h40, 8'h00, 2'b01, 8'h7F, 4'd7, 1, 0, 0, 0, 2'b01};
        tbl[19] = '{1'b0, 2'b10, 8'h00, 8'h80, 2'b10, 8'hFF, 4'd8, 0, 1, 0, 0, 2'b01};
        tbl[20] = '{1'b0, 2'b11, 8'h01, 8'h02, 2'b00, 8'hFF, 4'd8, 0, 1, 0, 0, 2'b01};
        tbl[21] = '{1'b1, 2'b11, 8'h01, 8'h02, 2'b00, 8'h00, 4'd0, 1, 0, 0, 0, 2'b01};

        rst = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 2'b11, 8'h01, 8'h02);
        #1;
        chk("reset_latch", 0, 32'(latch), 32'h00);
        chk("reset_cnt", 0, 32'(set_cnt), 32'd0);
        chk("reset_busy", 0, 32'(busy), 32'd0);
        chk("reset_done", 0, 32'(done), 32'd0);
        chk("reset_rej_valid", 0, 32'(rej_valid), 32'd0);
        chk("idle_ready", 0, 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("idle_stays", 0, 32'(busy), 32'd0);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].b0, tbl[i].b1);
            #1;
            chk("ready", i, 32'(req_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk("latch", i, 32'(latch), 32'(tbl[i].lat));
            chk("set_cnt", i, 32'(set_cnt), 32'(tbl[i].cnt));
            chk("busy", i, 32'(busy), 32'(tbl[i].bsy));
            chk("done", i, 32'(done), 32'(tbl[i].dn));
            chk("rej_valid", i, 32'(rej_valid), 32'(tbl[i].rv));
            chk("rej_id", i, 32'(rej_id), 32'(tbl[i].rid));
            chk("rej_code", i, 32'(rej_code), 32'(tbl[i].rcode));
        end

        // Build latch=8'h3C in a fresh session, then reset asynchronously between edges.
        drive(1'b0, 2'b01, 8'h04, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b01, 8'h08, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b01, 8'h10, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b01, 8'h20, 8'h00);
        @(posedge clk);
        #1;
        chk("pre_rst_latch", 0, 32'(latch), 32'h3C);
        chk("pre_rst_cnt", 0, 32'(set_cnt), 32'd4);
        drive(1'b1, 2'b00, 8'h00, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_latch", 0, 32'(latch), 32'h00);
        chk("async_rst_cnt", 0, 32'(set_cnt), 32'd0);
        chk("async_rst_busy", 0, 32'(busy), 32'd0);
        chk("async_rst_rej_code", 0, 32'(rej_code), 32'd0);
        @(posedge clk);
        #1;
        chk("start_ignored_in_rst", 0, 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("start_after_rst", 0, 32'(busy), 32'd1);
        chk("start_after_rst_latch", 0, 32'(latch), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
